// File: rtl/recorder_pkg.sv
// recorder_pkg: shared types and constants for sample_recorder.
// Holds the recorder state enum and the low-pass FIR configuration used
// when the design is built with RECORDER_FIR_EN.
package recorder_pkg;

  typedef enum logic [1:0] {
    REC  = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } rec_state_e;

  localparam int TAPS       = 31;
  localparam int COEF_W     = 10;
  localparam int COEF_SHIFT = 10;

  // Symmetric triangular low-pass kernel; the taps sum to 1024 = 1.0 << COEF_SHIFT,
  // so a constant input comes out of the filter unchanged.
  localparam logic signed [COEF_W-1:0] FIR_COEF [TAPS] = '{
    10'sd4,  10'sd8,  10'sd12, 10'sd16, 10'sd20, 10'sd24, 10'sd28, 10'sd32,
    10'sd36, 10'sd40, 10'sd44, 10'sd48, 10'sd52, 10'sd56, 10'sd60, 10'sd64,
    10'sd60, 10'sd56, 10'sd52, 10'sd48, 10'sd44, 10'sd40, 10'sd36, 10'sd32,
    10'sd28, 10'sd24, 10'sd20, 10'sd16, 10'sd12, 10'sd8,  10'sd4
  };

endpackage

// File: rtl/fir_lowpass.sv
// fir_lowpass: sequential TAPS-tap low-pass FIR, one multiply-accumulate per cycle.
// A start pulse pushes din into a 32-entry circular history; done pulses TAPS+1
// cycles later with the shifted, saturated result on dout.
module fir_lowpass
  import recorder_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] dout,
  output logic                     done
);

  localparam int ACC_W = DATA_W + COEF_W + 5;
  localparam logic [4:0] K_LAST = 5'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (DATA_W - 1)));

  logic signed [DATA_W-1:0]        samp_q [32];
  logic [4:0]                      wp_q, wp_d, base_q, base_d, k_q, k_d, rd_idx;
  logic                            busy_q, busy_d, fin_q, fin_d, done_q, done_d;
  logic signed [ACC_W-1:0]         acc_q, acc_d, shifted;
  logic signed [DATA_W-1:0]        dout_q, dout_d;
  logic signed [DATA_W+COEF_W-1:0] prod;

  // MAC sequencing: newest sample is at base, tap k reads base-k modulo 32
  always_comb begin
    wp_d    = wp_q;
    base_d  = base_q;
    k_d     = k_q;
    busy_d  = busy_q;
    acc_d   = acc_q;
    fin_d   = 1'b0;
    done_d  = fin_q;
    dout_d  = dout_q;
    rd_idx  = base_q - k_q;
    prod    = samp_q[rd_idx] * FIR_COEF[k_q];
    shifted = acc_q >>> COEF_SHIFT;
    if (fin_q) begin
      if (shifted > SAT_MAX)      dout_d = SAT_MAX[DATA_W-1:0];
      else if (shifted < SAT_MIN) dout_d = SAT_MIN[DATA_W-1:0];
      else                        dout_d = shifted[DATA_W-1:0];
    end
    if (start) begin
      wp_d   = wp_q + 5'd1;
      base_d = wp_q;
      k_d    = '0;
      acc_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = acc_q + ACC_W'(prod);
      k_d   = k_q + 5'd1;
      if (k_q == K_LAST) begin
        busy_d = 1'b0;
        fin_d  = 1'b1;
      end
    end
  end

  // State and sample history registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) samp_q[i] <= '0;
      wp_q   <= '0;
      base_q <= '0;
      k_q    <= '0;
      busy_q <= 1'b0;
      fin_q  <= 1'b0;
      done_q <= 1'b0;
      acc_q  <= '0;
      dout_q <= '0;
    end else begin
      if (start) samp_q[wp_q] <= din;
      wp_q   <= wp_d;
      base_q <= base_d;
      k_q    <= k_d;
      busy_q <= busy_d;
      fin_q  <= fin_d;
      done_q <= done_d;
      acc_q  <= acc_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
  assign done = done_q;

endmodule

// File: rtl/sample_recorder.sv
// sample_recorder: record every DECIM-th codec sample into a 2**ADDR_W RAM,
// then replay each stored sample for DECIM frames, once or looping.
// Optional feature macro: RECORDER_FIR_EN adds a low-pass FIR in the record path,
// selected at run time by the filter input.
module sample_recorder
  import recorder_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int DECIM  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              playback,
  input  logic              loop,
  input  logic              ready,
  input  logic              filter,
  input  logic [DATA_W-1:0] from_ac97_data,
  output logic [DATA_W-1:0] to_ac97_data,
  output logic              recording,
  output logic              playing,
  output logic              full,
  output logic [ADDR_W:0]   length
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [ADDR_W:0]  LEN_LAST = (ADDR_W + 1)'(DEPTH - 1);

  rec_state_e          state_q, state_d;
  logic                pb_q, pb_d, pb_prev_q, pb_prev_d, rise, fall;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d, wq_addr_q, wq_addr_d;
  logic [ADDR_W:0]     length_q, length_d, rd_addr_q, rd_addr_d, rd_base;
  logic                full_q, full_d, wr_en_q, wr_en_d, play_out_q, play_out_d, rd_at_end;
  logic [CNT_W-1:0]    decim_q, decim_d, hold_q, hold_d;
  logic [DATA_W-1:0]   out_q, out_d, wq_data_q, wq_data_d, rd_data_q;
  logic [ADDR_W-1:0]   rd_sel, mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_q [DEPTH];

`ifdef RECORDER_FIR_EN
  logic signed [DATA_W-1:0] fir_dout;
  logic                     fir_done;
  logic                     pend_q, pend_d;
  logic [ADDR_W-1:0]        pend_addr_q, pend_addr_d;

  // Every codec frame goes through the filter so it works as the anti-alias stage
  fir_lowpass #(.DATA_W(DATA_W)) u_fir (
    .clock (clock),
    .reset (reset),
    .start (ready),
    .din   (from_ac97_data),
    .dout  (fir_dout),
    .done  (fir_done)
  );
`else
  logic unused_filter;
  assign unused_filter = filter;
`endif

  assign rise      = pb_q & ~pb_prev_q;
  assign fall      = ~pb_q & pb_prev_q;
  assign rd_at_end = (rd_addr_q == length_q);
  assign rd_sel    = rd_at_end ? '0 : rd_addr_q[ADDR_W-1:0];
  assign rd_base   = rd_at_end ? '0 : rd_addr_q;

  // Next-state and datapath control; a mode edge swallows a coincident ready
  always_comb begin
    state_d    = state_q;
    pb_d       = playback;
    pb_prev_d  = pb_q;
    wr_addr_d  = wr_addr_q;
    length_d   = length_q;
    full_d     = full_q;
    decim_d    = decim_q;
    rd_addr_d  = rd_addr_q;
    hold_d     = hold_q;
    wr_en_d    = 1'b0;
    wq_addr_d  = wq_addr_q;
    wq_data_d  = wq_data_q;
    play_out_d = 1'b0;
    out_d      = out_q;
`ifdef RECORDER_FIR_EN
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    if (pend_q && fir_done) pend_d = 1'b0;
`endif
    if (rise) begin
      state_d   = PLAY;
      rd_addr_d = '0;
      hold_d    = '0;
`ifdef RECORDER_FIR_EN
      pend_d    = 1'b0;
`endif
    end else if (fall) begin
      state_d   = REC;
      wr_addr_d = '0;
      length_d  = '0;
      full_d    = 1'b0;
      decim_d   = '0;
`ifdef RECORDER_FIR_EN
      pend_d    = 1'b0;
`endif
    end else begin
      case (state_q)
        REC: if (ready) begin
          out_d   = from_ac97_data;
          decim_d = (decim_q == CNT_LAST) ? '0 : decim_q + 1'b1;
          if (decim_q == '0 && !full_q) begin
            wr_addr_d = wr_addr_q + 1'b1;
            length_d  = length_q + 1'b1;
            if (length_q == LEN_LAST) full_d = 1'b1;
`ifdef RECORDER_FIR_EN
            if (filter) begin
              pend_d      = 1'b1;
              pend_addr_d = wr_addr_q;
            end else begin
              wr_en_d   = 1'b1;
              wq_addr_d = wr_addr_q;
              wq_data_d = from_ac97_data;
            end
`else
            wr_en_d   = 1'b1;
            wq_addr_d = wr_addr_q;
            wq_data_d = from_ac97_data;
`endif
          end
        end
        PLAY: begin
          if (length_q == '0) begin
            state_d = DONE;
          end else if (ready) begin
            // End of recording is resolved at the next ready so the last sample gets its full hold
            if (rd_at_end && !loop) begin
              state_d = DONE;
            end else begin
              play_out_d = 1'b1;
              if (hold_q == CNT_LAST) begin
                hold_d    = '0;
                rd_addr_d = rd_base + 1'b1;
              end else begin
                hold_d    = hold_q + 1'b1;
                rd_addr_d = rd_base;
              end
            end
          end
        end
        default: ;
      endcase
    end
    if (play_out_q) out_d = rd_data_q;
    if (state_q == DONE) out_d = '0;
  end

  // Control and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= REC;
      pb_q       <= 1'b0;
      pb_prev_q  <= 1'b0;
      wr_addr_q  <= '0;
      length_q   <= '0;
      full_q     <= 1'b0;
      decim_q    <= '0;
      rd_addr_q  <= '0;
      hold_q     <= '0;
      wr_en_q    <= 1'b0;
      wq_addr_q  <= '0;
      wq_data_q  <= '0;
      play_out_q <= 1'b0;
      out_q      <= '0;
`ifdef RECORDER_FIR_EN
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pb_q       <= pb_d;
      pb_prev_q  <= pb_prev_d;
      wr_addr_q  <= wr_addr_d;
      length_q   <= length_d;
      full_q     <= full_d;
      decim_q    <= decim_d;
      rd_addr_q  <= rd_addr_d;
      hold_q     <= hold_d;
      wr_en_q    <= wr_en_d;
      wq_addr_q  <= wq_addr_d;
      wq_data_q  <= wq_data_d;
      play_out_q <= play_out_d;
      out_q      <= out_d;
`ifdef RECORDER_FIR_EN
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
`endif
    end
  end

  // RAM write port: raw samples one cycle after ready, filtered ones on the FIR done pulse
  always_comb begin
    mem_we    = wr_en_q;
    mem_waddr = wq_addr_q;
    mem_wdata = wq_data_q;
`ifdef RECORDER_FIR_EN
    if (pend_q && fir_done) begin
      mem_we    = 1'b1;
      mem_waddr = pend_addr_q;
      mem_wdata = fir_dout;
    end
`endif
  end

  // Sample RAM with registered read; contents survive reset
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    rd_data_q <= mem_q[rd_sel];
  end

  assign to_ac97_data = out_q;
  assign recording    = (state_q == REC) && !full_q;
  assign playing      = (state_q == PLAY);
  assign full         = full_q;
  assign length       = length_q;

endmodule
